// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch (ibus), data (dbus) and shared core-bus (cbus) signals
// plus the pipeline stall outputs. The arbiter uses the slave modport; the
// environment (pipeline requesters and cbus responder) uses the master modport.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  // fetch port
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_data_ok;
  logic [31:0]       iresp_data;
  // data port
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;
  // shared core bus
  logic              creq_valid;
  logic [ADDR_W-1:0] creq_addr;
  logic [2:0]        creq_size;
  logic [7:0]        creq_strobe;
  logic [DATA_W-1:0] creq_data;
  logic              cresp_ready;
  logic              cresp_last;
  logic [DATA_W-1:0] cresp_data;
  // pipeline stall
  logic              handshake_stall;
  logic [63:0]       stall_cycles;

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_data_ok, dresp_data,
    input  creq_valid, creq_addr, creq_size, creq_strobe, creq_data,
    output cresp_ready, cresp_last, cresp_data,
    input  handshake_stall, stall_cycles
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_data_ok, dresp_data,
    output creq_valid, creq_addr, creq_size, creq_strobe, creq_data,
    input  cresp_ready, cresp_last, cresp_data,
    output handshake_stall, stall_cycles
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / data) arbiter onto the single core memory bus. One
// transaction at a time, request held in registers until the last response
// beat, alternating priority on ties, plus pipeline stall and stall counter.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [2:0] FETCH_SIZE = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state;
  logic              last_d;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [7:0]        req_strobe;
  logic [DATA_W-1:0] req_data;
  logic [63:0]       stall_cnt;

  logic beat_done;
  logic grant_d;
  logic iok;
  logic dok;
  logic stall;

  // Completion detection, tie-break choice and stall request
  always_comb begin
    beat_done = bus.cresp_ready & bus.cresp_last;
    grant_d   = bus.dreq_valid & (~bus.ireq_valid | ~last_d);
    iok       = (state == BUSY_I) & beat_done;
    dok       = (state == BUSY_D) & beat_done;
    stall     = (bus.ireq_valid & ~iok) | (bus.dreq_valid & ~dok);
  end

  // Arbitration FSM; request fields are latched on the grant edge only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      req_addr   <= '0;
      req_size   <= '0;
      req_strobe <= '0;
      req_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= BUSY_D;
            req_addr   <= bus.dreq_addr;
            req_size   <= bus.dreq_size;
            req_strobe <= bus.dreq_strobe;
            req_data   <= bus.dreq_data;
          end else if (bus.ireq_valid) begin
            state      <= BUSY_I;
            req_addr   <= bus.ireq_addr;
            req_size   <= FETCH_SIZE;
            req_strobe <= 8'h00;
            req_data   <= '0;
          end
        end
        BUSY_I: begin
          if (beat_done) begin
            state  <= IDLE;
            last_d <= 1'b0;
          end
        end
        BUSY_D: begin
          if (beat_done) begin
            state  <= IDLE;
            last_d <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Consecutive-stall counter, cleared by any non-stall cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 64'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 64'd1;
    end else begin
      stall_cnt <= 64'd0;
    end
  end

  // cbus request comes only from the latched registers
  assign bus.creq_valid  = (state != IDLE);
  assign bus.creq_addr   = req_addr;
  assign bus.creq_size   = req_size;
  assign bus.creq_strobe = req_strobe;
  assign bus.creq_data   = req_data;

  // Per-port completion and response data
  assign bus.iresp_data_ok = iok;
  assign bus.dresp_data_ok = dok;
  assign bus.iresp_data    = req_addr[2] ? bus.cresp_data[63:32] : bus.cresp_data[31:0];
  assign bus.dresp_data    = bus.cresp_data;

  assign bus.handshake_stall = stall;
  assign bus.stall_cycles    = stall_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: two requesters and a cbus
// responder drive traffic; a negedge monitor checks against a reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // requester-side drive (requests are dropped by the pipeline on reset)
  logic        ireq_v = 1'b0;
  logic [63:0] ireq_a = 64'd0;
  logic        dreq_v = 1'b0;
  logic [63:0] dreq_a = 64'd0;
  logic [2:0]  dreq_s = 3'd0;
  logic [7:0]  dreq_st = 8'd0;
  logic [63:0] dreq_d = 64'd0;
  // responder-side drive
  logic        rsp_ready = 1'b0;
  logic        rsp_last = 1'b0;
  logic [63:0] rsp_data = 64'd0;

  assign bus.ireq_valid  = ireq_v & rst_n;
  assign bus.ireq_addr   = ireq_a;
  assign bus.dreq_valid  = dreq_v & rst_n;
  assign bus.dreq_addr   = dreq_a;
  assign bus.dreq_size   = dreq_s;
  assign bus.dreq_strobe = dreq_st;
  assign bus.dreq_data   = dreq_d;
  assign bus.cresp_ready = rsp_ready;
  assign bus.cresp_last  = rsp_last;
  assign bus.cresp_data  = rsp_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard queues, one per port, in issue order
  req_t i_q[$];
  req_t d_q[$];

  logic en_i = 1'b0;
  logic en_d = 1'b0;

  // responder / model state
  logic        active = 1'b0;     // a transaction is on the cbus
  logic        owner = 1'b0;      // 1: data port, 0: fetch port
  logic        done_pend = 1'b0;  // last beat presented this cycle
  logic        last_now = 1'b0;
  logic        idle_prev = 1'b1;  // arbiter was idle in the previous cycle
  logic [63:0] cap_addr = 64'd0;
  logic [2:0]  cap_size = 3'd0;
  logic [7:0]  cap_strobe = 8'd0;
  logic [63:0] cap_data = 64'd0;
  logic [63:0] beat_data = 64'd0;
  int          beats_left = 0;
  int          wait_cnt = 0;

  // monitor-side model state
  logic        last_model = 1'b0; // port of the last completed transaction
  logic [63:0] exp_cnt = 64'd0;
  logic        fin_i = 1'b0;
  logic        fin_d = 1'b0;

  // Requesters: issue, hold until completion, then optionally re-issue
  int gap_i = 0;
  int gap_d = 0;
  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      ireq_v = 1'b0;
      dreq_v = 1'b0;
      gap_i = 0;
      gap_d = 0;
    end else begin
      if (ireq_v && fin_i) ireq_v = 1'b0;
      if (dreq_v && fin_d) dreq_v = 1'b0;
      if (dreq_v && !fin_d && active && owner) begin
        dreq_a = {1'b1, 63'({$urandom, $urandom})};
        dreq_s = 3'($urandom);
        dreq_st = 8'($urandom);
        dreq_d = {$urandom, $urandom};
      end
      if (!ireq_v && en_i) begin
        if (gap_i > 0) gap_i--;
        else begin
          req_t r;
          r.addr = {1'b0, 61'({$urandom, $urandom}), 2'b00};
          r.size = 3'b010;
          r.strobe = 8'h00;
          r.data = 64'd0;
          ireq_a = r.addr;
          ireq_v = 1'b1;
          i_q.push_back(r);
          gap_i = int'($urandom_range(0, 3));
        end
      end
      if (!dreq_v && en_d) begin
        if (gap_d > 0) gap_d--;
        else begin
          req_t r;
          r.addr = {1'b1, 63'({$urandom, $urandom})};
          r.size = 3'($urandom);
          r.strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
          r.data = {$urandom, $urandom};
          dreq_a = r.addr;
          dreq_s = r.size;
          dreq_st = r.strobe;
          dreq_d = r.data;
          dreq_v = 1'b1;
          d_q.push_back(r);
          gap_d = int'($urandom_range(0, 3));
        end
      end
    end
  end

  task automatic drive_beat();
    rsp_data = {$urandom, $urandom};
    if (wait_cnt > 0) begin
      wait_cnt--;
      rsp_ready = 1'b0;
      rsp_last = 1'($urandom_range(0, 1));
    end else begin
      rsp_ready = 1'b1;
      beats_left--;
      rsp_last = (beats_left == 0);
      if (rsp_last) begin
        last_now = 1'b1;
        done_pend = 1'b1;
        beat_data = rsp_data;
      end else begin
        wait_cnt = int'($urandom_range(0, 2));
      end
    end
  endtask

  // cbus responder plus grant timing / alternation reference
  always begin
    logic pend_i;
    logic pend_d;
    logic exp_cv;
    logic exp_owner;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      active = 1'b0;
      done_pend = 1'b0;
      last_now = 1'b0;
      rsp_ready = 1'b0;
      rsp_last = 1'b0;
      idle_prev = 1'b1;
    end else if (active && done_pend) begin
      active = 1'b0;
      done_pend = 1'b0;
      last_now = 1'b0;
      rsp_ready = 1'b0;
      rsp_last = 1'b0;
      chk("creq_valid_after_last", 64'(bus.creq_valid), 64'd0);
      idle_prev = 1'b1;
    end else if (active) begin
      drive_beat();
    end else begin
      pend_i = bus.ireq_valid;
      pend_d = bus.dreq_valid;
      exp_cv = idle_prev && (pend_i || pend_d);
      chk("creq_valid_grant", 64'(bus.creq_valid), 64'(exp_cv));
      if (bus.creq_valid) begin
        active = 1'b1;
        owner = bus.creq_addr[63];
        if (exp_cv) begin
          exp_owner = (pend_i && pend_d) ? !last_model : pend_d;
          chk("grant_port", 64'(owner), 64'(exp_owner));
        end
        cap_addr = bus.creq_addr;
        cap_size = bus.creq_size;
        cap_strobe = bus.creq_strobe;
        cap_data = bus.creq_data;
        beats_left = int'($urandom_range(1, 3));
        wait_cnt = int'($urandom_range(0, 2));
        drive_beat();
      end
      idle_prev = !bus.creq_valid;
    end
  end

  // Monitor: per-cycle outputs, stall model, scoreboard pops on data_ok
  always @(negedge clk) begin
    logic exp_i;
    logic exp_d;
    logic exp_stall;
    req_t r;
    if (!rst_n) begin
      chk("rst_creq_valid", 64'(bus.creq_valid), 64'd0);
      chk("rst_iok", 64'(bus.iresp_data_ok), 64'd0);
      chk("rst_dok", 64'(bus.dresp_data_ok), 64'd0);
      i_q.delete();
      d_q.delete();
      exp_cnt = 64'd0;
      last_model = 1'b0;
      fin_i = 1'b0;
      fin_d = 1'b0;
    end else begin
      exp_i = last_now && !owner;
      exp_d = last_now && owner;
      chk("iresp_data_ok", 64'(bus.iresp_data_ok), 64'(exp_i));
      chk("dresp_data_ok", 64'(bus.dresp_data_ok), 64'(exp_d));
      exp_stall = (bus.ireq_valid && !exp_i) || (bus.dreq_valid && !exp_d);
      chk("handshake_stall", 64'(bus.handshake_stall), 64'(exp_stall));
      chk("stall_cycles", bus.stall_cycles, exp_cnt);
      exp_cnt = exp_stall ? exp_cnt + 64'd1 : 64'd0;
      if (active) begin
        chk("creq_addr_stable", bus.creq_addr, cap_addr);
        chk("creq_size_stable", 64'(bus.creq_size), 64'(cap_size));
        chk("creq_strobe_stable", 64'(bus.creq_strobe), 64'(cap_strobe));
        chk("creq_data_stable", bus.creq_data, cap_data);
      end
      if (bus.iresp_data_ok) begin
        if (i_q.size() == 0) chk("i_queue_nonempty", 64'd0, 64'd1);
        else begin
          r = i_q.pop_front();
          chk("i_addr", cap_addr, r.addr);
          chk("i_size", 64'(cap_size), 64'(r.size));
          chk("i_strobe", 64'(cap_strobe), 64'(r.strobe));
          chk("iresp_data", 64'(bus.iresp_data),
              64'(r.addr[2] ? beat_data[63:32] : beat_data[31:0]));
        end
      end
      if (bus.dresp_data_ok) begin
        if (d_q.size() == 0) chk("d_queue_nonempty", 64'd0, 64'd1);
        else begin
          r = d_q.pop_front();
          chk("d_addr", cap_addr, r.addr);
          chk("d_size", 64'(cap_size), 64'(r.size));
          chk("d_strobe", 64'(cap_strobe), 64'(r.strobe));
          chk("d_data", cap_data, r.data);
          chk("dresp_data", bus.dresp_data, beat_data);
        end
      end
      if (last_now) last_model = owner;
      fin_i = exp_i;
      fin_d = exp_d;
    end
  end

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    // quiet period: no requests, no bus activity, counter stays 0
    repeat (10) @(posedge clk);
    en_i = 1'b1;
    en_d = 1'b1;
    repeat (3000) @(posedge clk);
    // async reset while a data transaction is in flight
    en_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (active && owner && !last_now) found = 1'b1;
    end
    chk("reset_target_found", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    en_d = 1'b0;
    #1;
    chk("async_rst_creq_valid", 64'(bus.creq_valid), 64'd0);
    chk("async_rst_stall", 64'(bus.handshake_stall), 64'd0);
    chk("async_rst_iok", 64'(bus.iresp_data_ok), 64'd0);
    chk("async_rst_dok", 64'(bus.dresp_data_ok), 64'd0);
    chk("async_rst_stall_cycles", bus.stall_cycles, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    // both ports issue together right after release: first tie goes to D
    en_i = 1'b1;
    en_d = 1'b1;
    repeat (600) @(posedge clk);
    en_i = 1'b0;
    en_d = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("i_queue_drained", 64'(i_q.size()), 64'd0);
    chk("d_queue_drained", 64'(d_q.size()), 64'd0);
    chk("final_creq_valid", 64'(bus.creq_valid), 64'd0);
    chk("final_stall_cycles", bus.stall_cycles, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single core memory bus (cbus) between the instruction-fetch request port (ibus) and the memory-stage data request port (dbus). It serialises one transaction at a time, holds each granted request stable on the cbus until the last response beat, and returns per-port `data_ok` pulses. It also drives the pipeline-wide `handshake_stall` and a stall-cycle counter consumed by the stage registers.

## Interface
Parameters:
- `ADDR_W`, 64, request address width.
- `DATA_W`, 64, cbus data width; ibus returns 32 bits.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted low.
- `ireq_valid`  in  1  fetch request; held high until `iresp_data_ok`.
- `ireq_addr`  in  ADDR_W  fetch address.
- `iresp_data_ok`  out  1  one-cycle completion pulse for the fetch.
- `iresp_data`  out  32  instruction word.
- `dreq_valid`  in  1  data request; held high until `dresp_data_ok`.
- `dreq_addr`  in  ADDR_W  data address.
- `dreq_size`  in  3  access size code.
- `dreq_strobe`  in  8  byte write strobe; 0 means read.
- `dreq_data`  in  DATA_W  store data.
- `dresp_data_ok`  out  1  one-cycle completion pulse for the data access.
- `dresp_data`  out  DATA_W  load data.
- `creq_valid`, `creq_addr`, `creq_size`, `creq_strobe`, `creq_data`  out  1/ADDR_W/3/8/DATA_W  cbus request.
- `cresp_ready`  in  1  response beat valid.
- `cresp_last`  in  1  final beat of the transaction.
- `cresp_data`  in  DATA_W  response data.
- `handshake_stall`  out  1  pipeline stall request.
- `stall_cycles`  out  64  number of consecutive cycles `handshake_stall` has been high.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE transitions:
  - Only `dreq_valid` high: go to BUSY_D.
  - Only `ireq_valid` high: go to BUSY_I.
  - Both high: grant the port not granted last. The `last_d` flag resets to 0, so D wins the first tie.
  - Neither high: stay in IDLE.
- Request capture: on the grant edge, the selected port's addr/size/strobe/data are copied into request registers.
  - A fetch is captured with `size` = 3'b010 and `strobe` = 0.
  - `creq_*` are driven only from these registers, so they stay stable for the whole transaction.
  - `creq_valid` = 1 in BUSY_I or BUSY_D, otherwise 0.
- Completion condition: in BUSY_X, `cresp_ready & cresp_last`.
  - Raises `X_data_ok` combinationally in the same cycle.
  - Sets `last_d` = (X == D).
  - Returns the FSM to IDLE on the next edge.
- Beats with `cresp_ready` = 1 and `cresp_last` = 0 are ignored; there is no ok pulse.
- Response data:
  - `iresp_data` = `creq_addr[2]` ? `cresp_data[63:32]` : `cresp_data[31:0]`.
  - `dresp_data` = `cresp_data`.
  - Both are don't-care when their `data_ok` is 0.
- An in-flight transaction is never aborted by pipeline flush or jump; the requester discards the result.
- `handshake_stall` = (`ireq_valid & ~iresp_data_ok`) | (`dreq_valid & ~dresp_data_ok`), combinational.
- `stall_cycles`:
  - Increments each edge while `handshake_stall` = 1.
  - Clears to 0 on any edge where `handshake_stall` = 0.
  - Wraps modulo 2^64.

## Timing
- Reset (low, async): state = IDLE, `last_d` = 0, request registers = 0, `stall_cycles` = 0.
  - While reset is held: `creq_valid` = 0, both `data_ok` = 0.
  - Reset mid-transaction drops `creq_valid` immediately; the cbus slave must tolerate this.
- Request at cycle t in IDLE: `creq_valid` = 1 from cycle t+1.
- Response at cycle t+k (k ≥ 1): `data_ok` in cycle t+k, IDLE at t+k+1, next grant visible at t+k+2.
- Minimum latency is 1 cycle from grant to `data_ok`, giving one transaction every 2 cycles at best.
- A request whose valid drops before completion is a protocol violation.
  - The arbiter still completes the captured transaction and pulses `data_ok`.
- Simultaneous completion of X and a new request from X: the new request is not granted before the IDLE cycle.

## Test plan
- Single fetch: `ireq_valid` = 1, addr 0x8000_0004; `cresp_last` returned 2 cycles after `creq_valid` with data 0xAAAA_BBBB_CCCC_DDDD -> `creq_valid` at t+1, `iresp_data_ok` pulse at t+3 with `iresp_data` = 0xAAAA_BBBB, `stall_cycles` = 3 that cycle, then 0.
- Tie alternation: I and D held high continuously, each response in 1 cycle -> grant order D, I, D, I; `dresp_data_ok` and `iresp_data_ok` alternate every 2 cycles.
- Request stability: grant D store (addr 0x100, strobe 0xFF, data 0x1234); change `dreq_*` inputs during a 5-cycle wait -> `creq_*` stay 0x100/0xFF/0x1234 until `cresp_last`.
- Multi-beat: 3 `cresp_ready` beats, only the 3rd with `cresp_last` -> exactly one `data_ok`, on beat 3.
- Async reset mid-transaction in BUSY_D: drive reset low between edges -> `creq_valid` and `handshake_stall` (no requests) drop without a clock edge; after release the first tie grants D.
- Idle: no requests for 10 cycles -> `creq_valid` = 0, `handshake_stall` = 0, `stall_cycles` = 0 throughout.
